// File: rtl/serial_att_loader.sv
// Serial loader for a bank of digital step attenuators sharing one CLK/DAT pair.
// Each channel is resent whenever its input word drifts from what was last latched.

module serial_att_lane #(
  parameter int WIDTH = 6
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_att,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_force,
  input  logic             i_active,
  input  logic             i_clr,
  input  logic             i_take,
  output logic             o_pend
);
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_ref;
  logic             r_pend;
  logic             w_set;

  // While this lane is on the wire, compare against the captured word so the
  // stale shadow does not queue a duplicate frame.
  assign w_ref = i_active ? i_word : r_shadow;
  assign w_set = i_force | ((i_att != w_ref) & ~i_clr);
  assign o_pend = r_pend;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shadow <= '0;
      r_pend   <= 1'b1;
    end else begin
      r_pend <= (r_pend & ~i_clr) | w_set;
      if (i_take) r_shadow <= i_word;
    end
  end
endmodule

module serial_att_loader #(
  parameter int CH        = 2,
  parameter int WIDTH     = 6,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [CH*WIDTH-1:0]   i_att,
  input  logic                  i_force,
  output logic                  o_clk,
  output logic                  o_dat,
  output logic [CH-1:0]         o_en,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int              BW       = $clog2(WIDTH + 1);
  localparam int              SW       = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [7:0]      PH_LAST  = 8'(DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LATCH, S_GAP} state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_phase;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shift, r_word, w_pick_word;
  logic [SW-1:0]    r_sel, w_pick;
  logic [CH-1:0]    w_pend, w_clr, w_active;
  logic             w_any, w_start, w_ph_end, w_take;

  assign w_ph_end = (r_phase == PH_LAST);
  assign w_start  = (r_state == S_IDLE) && w_any;
  assign w_take   = (r_state == S_HIGH) && w_ph_end && (r_bit == BIT_LAST);

  // Descending scan so the lowest pending index wins.
  always_comb begin
    w_pick      = '0;
    w_pick_word = '0;
    w_any       = 1'b0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (w_pend[c]) begin
        w_pick      = SW'(c);
        w_pick_word = i_att[c*WIDTH +: WIDTH];
        w_any       = 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    assign w_clr[c]    = w_start && (w_pick == SW'(c));
    assign w_active[c] = (r_state != S_IDLE) && (r_sel == SW'(c));

    serial_att_lane #(.WIDTH(WIDTH)) u_lane (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_att    (i_att[c*WIDTH +: WIDTH]),
      .i_word   (r_word),
      .i_force  (i_force),
      .i_active (w_active[c]),
      .i_clr    (w_clr[c]),
      .i_take   (w_take && (r_sel == SW'(c))),
      .o_pend   (w_pend[c])
    );
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)    w_next = S_SETUP;
      S_SETUP: if (w_ph_end) w_next = S_HIGH;
      S_HIGH:  if (w_ph_end) w_next = (r_bit == BIT_LAST) ? S_LATCH : S_SETUP;
      S_LATCH: if (w_ph_end) w_next = S_GAP;
      S_GAP:   if (w_ph_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      r_phase <= ((w_next != r_state) || (r_state == S_IDLE)) ? 8'd0 : 8'(r_phase + 8'd1);
      if (w_start) begin
        r_shift <= w_pick_word;
        r_word  <= w_pick_word;
        r_sel   <= w_pick;
        r_bit   <= '0;
      end else if ((r_state == S_HIGH) && w_ph_end) begin
        r_bit   <= BW'(r_bit + 1'b1);
        r_shift <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
      end
    end
  end

  // Outputs decode registered state only, so DAT is already settled when CLK rises.
  assign o_clk  = (r_state == S_HIGH);
  assign o_dat  = ((r_state == S_SETUP) || (r_state == S_HIGH)) ?
                  ((MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0]) : 1'b0;
  assign o_en   = (r_state == S_LATCH) ? (CH'(1) << r_sel) : '0;
  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_GAP) && w_ph_end;
endmodule

// File: doc/serial_att_loader.md
SERIAL_ATT_LOADER -- requirements
Module: serial_att_loader

Interface
REQ-001 Parameter CH, default 2: number of attenuator channels sharing CLK/DAT; legal 1..8.
REQ-002 Parameter WIDTH, default 6: control-word bits per channel; legal 1..16.
REQ-003 Parameter DIV, default 1: clock cycles per serial phase; legal 1..255.
REQ-004 Parameter MSB_FIRST, default 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
REQ-005 clock  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 att  in  CH*WIDTH  channel c word at bits [c*WIDTH +: WIDTH]; level-sampled.
REQ-008 force  in  1  one-cycle pulse; marks every channel for reload.
REQ-009 CLK  out  1  serial clock to attenuators.
REQ-010 DAT  out  1  serial data; stable for the whole CLK-high phase.
REQ-011 EN  out  CH  per-channel latch enable, active-high, one-hot or zero.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 done  out  1  one-cycle pulse at the end of each channel frame.

Function
REQ-014 The block SHALL keep a per-channel shadow register holding the last word loaded and a per-channel pending flag.
REQ-015 pending[c] SHALL be set in any cycle where att word c differs from shadow[c], or where force=1.
REQ-016 FSM states: IDLE, SETUP, HIGH, LATCH, GAP.
REQ-017 IDLE: if any pending bit is set, select the lowest-index pending channel, copy its att word into the shift register, clear its pending flag, and go to SETUP; otherwise stay in IDLE.
REQ-018 SETUP: drive DAT with the current bit and CLK=0 for DIV cycles, then go to HIGH.
REQ-019 HIGH: drive CLK=1 with DAT unchanged for DIV cycles; then go to SETUP with the next bit, or to LATCH after bit WIDTH.
REQ-020 LATCH: drive CLK=0 and EN[sel]=1 for DIV cycles; shadow[sel] SHALL take the captured word on entry.
REQ-021 GAP: drive all outputs low except busy for DIV cycles; assert done during the final GAP cycle; then go to IDLE.
REQ-022 Frame length SHALL be 1 + 2*DIV*WIDTH + 2*DIV cycles, from IDLE selection to return to IDLE.
REQ-023 A word changing mid-frame SHALL NOT alter the frame in progress.
  - Its pending flag is set again (shadow mismatch), so the new value is sent in a later frame.
REQ-024 force during a frame SHALL mark all channels, including the active one, for reload after the current frame.
REQ-025 Arbitration SHALL be fixed-priority by lowest index; a continuously changing low channel may starve higher ones, and this is accepted.
REQ-026 The phase counter SHALL be 8 bits and the bit counter ceil(log2(WIDTH+1)) bits; neither wraps within a legal frame.
REQ-027 DAT and EN SHALL never change in the same cycle as a CLK rising edge.
  - EN SHALL never be high while CLK is high.

Reset
REQ-028 With reset=1, on the next edge the block SHALL drive CLK=0, DAT=0, EN=0, busy=0, done=0 and set the FSM to IDLE.
REQ-029 Reset SHALL clear all shadow registers to 0 and set every pending flag to 1, so all channels are loaded once after reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no EN pulse; the aborted channel is reloaded afterwards.

Verification
REQ-031 CH=2, WIDTH=6, DIV=1, MSB_FIRST=1; release reset with att={6'h15,6'h2A}.
  - Response: channel 0 frame DAT=1,0,1,0,1,0 on six CLK pulses, then EN[0] for 1 cycle.
  - Then channel 1 frame DAT=0,1,0,1,0,1, then EN[1]; two done pulses.
  - Each frame is 15 cycles.
REQ-032 Idle with shadows equal; change ch1 word to 6'h3F.
  - Response: exactly one frame, all DAT=1, on EN[1] only; then busy=0.
REQ-033 DIV=3; start a ch0 frame with 6'h01; change ch0 to 6'h02 at bit 3.
  - Response: first frame completes with 6'h01 (each CLK high 3 cycles).
  - A second frame then sends 6'h02.
REQ-034 MSB_FIRST=0, word 6'h01: first DAT bit=1, remaining five bits=0.
REQ-035 Assert reset during HIGH of bit 2.
  - Response: next cycle CLK=DAT=EN=busy=0.
  - After release, both channels reload in index order.
REQ-036 Pulse force while ch1 is loading, with no word changes.
  - Response: after the current frame, ch0 reloads, then ch1 reloads; three done pulses total.
